mux_tree_pipe: RTL

- Parametrised, pipelined N:1 channel selector built as a binary tree of registered 2:1 mux stages.
- Successor to the combinational 4:1 tree. Adds:
  - generic channel count and width
  - a valid qualifier
  - an output channel tag
  - an auto-scan mode that steps through the channels.
- Sits between multi-channel sample sources (sensors/ADC lanes) and a single-lane consumer.

---
 rtl/mux_tree_pipe_pkg.sv | 20 ++
 rtl/mux_tree_pipe_if.sv | 28 ++
 rtl/mux_tree_pipe_stage.sv | 45 ++++
 rtl/mux_tree_pipe.sv | 73 +++++++
 4 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// Shared constants and helpers for the pipelined channel selector.
package mux_pkg;

    localparam int unsigned DEFAULT_NUM_CH = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;

    // Select width for a channel count: ceil(log2(n)), never below 1.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Sample bus between the channel sources/control and the single-lane consumer.
interface mux_tree_pipe_if
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);
    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     in_valid;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic                     scan_clr;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic [SEL_W-1:0]         out_ch;

    modport master (
        output in_data, in_valid, sel, mode, scan_clr,
        input  out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, sel, mode, scan_clr,
        output out_data, out_valid, out_ch
    );
endinterface

// File: rtl/mux_tree_pipe_stage.sv
// One registered level of the mux tree: halves the word count using one tag bit.
module mux_stage #(
    parameter int unsigned IN_WORDS = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned SEL_BIT  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_WORDS*DATA_W-1:0]       src_words,
    input  logic                             src_valid,
    input  logic [SEL_W-1:0]                 src_tag,
    output logic [(IN_WORDS/2)*DATA_W-1:0]   words,
    output logic                             valid,
    output logic [SEL_W-1:0]                 tag
);
    localparam int unsigned OUT_WORDS = IN_WORDS / 2;

    logic [OUT_WORDS*DATA_W-1:0] mux_words;

    // Pick odd or even member of each adjacent pair according to this level's tag bit.
    always_comb begin
        mux_words = '0;
        for (int unsigned i = 0; i < OUT_WORDS; i++) begin
            mux_words[i*DATA_W +: DATA_W] = src_tag[SEL_BIT]
                ? src_words[(2*i+1)*DATA_W +: DATA_W]
                : src_words[(2*i)*DATA_W +: DATA_W];
        end
    end

    // Valid advances every cycle; data and tag only load behind a valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            words <= '0;
            valid <= 1'b0;
            tag   <= '0;
        end else begin
            valid <= src_valid;
            if (src_valid) begin
                words <= mux_words;
                tag   <= src_tag;
            end
        end
    end
endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 channel selector: log2(N) registered 2:1 levels plus an auto-scan counter.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    mux_tree_pipe_if.slave   bus
);
    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic [SEL_W-1:0] scan_cnt;
    logic [SEL_W-1:0] eff_sel;

    // Select travels with the sample, so in-flight samples ignore later mode/sel changes.
    always_comb begin
        eff_sel = bus.mode ? scan_cnt : bus.sel;
    end

    // Scan counter: clear beats increment; wraps naturally since NUM_CH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (bus.scan_clr) begin
            scan_cnt <= '0;
        end else if (bus.mode && bus.in_valid) begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int unsigned IN_WORDS = NUM_CH >> k;

        logic [IN_WORDS*DATA_W-1:0]     src_words;
        logic                           src_valid;
        logic [SEL_W-1:0]               src_tag;
        logic [(IN_WORDS/2)*DATA_W-1:0] words;
        logic                           valid;
        logic [SEL_W-1:0]               tag;

        if (k == 0) begin : g_first
            assign src_words = bus.in_data;
            assign src_valid = bus.in_valid;
            assign src_tag   = eff_sel;
        end else begin : g_next
            assign src_words = g_lvl[k-1].words;
            assign src_valid = g_lvl[k-1].valid;
            assign src_tag   = g_lvl[k-1].tag;
        end

        mux_stage #(
            .IN_WORDS (IN_WORDS),
            .DATA_W   (DATA_W),
            .SEL_W    (SEL_W),
            .SEL_BIT  (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .src_words (src_words),
            .src_valid (src_valid),
            .src_tag   (src_tag),
            .words     (words),
            .valid     (valid),
            .tag       (tag)
        );
    end

    assign bus.out_data  = g_lvl[SEL_W-1].words;
    assign bus.out_valid = g_lvl[SEL_W-1].valid;
    assign bus.out_ch    = g_lvl[SEL_W-1].tag;
endmodule
